// File: rtl/hll_sketch_update.sv
// HyperLogLog sketch stage: keeps 2^P max-rank registers in block RAM, updates them
// from a 64-bit hash stream and streams the sketch out (then clears it) on request.
module hll_sketch_update #(
  parameter int unsigned P     = 14,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 48
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [63:0]      s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             dump_req,
  output logic [OUT_W-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             busy,
  output logic [CNT_W-1:0] item_count
);

  localparam int unsigned NB       = 2 ** P;
  localparam int unsigned FW       = 61 - P;
  localparam int unsigned RANK_W   = $clog2(63 - P);
  localparam int unsigned RANK_SAT = 62 - P;

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_DRAIN, S_DUMP} state_t;

  state_t              r_state;
  logic                r_s_tready;
  logic                r_m_tvalid;
  logic                r_m_tlast;
  logic [OUT_W-1:0]    r_m_tdata;
  logic                r_busy;
  logic [CNT_W-1:0]    r_item_count;
  logic [P-1:0]        r_clr_addr;
  logic [P:0]          r_rd_addr;
  logic                r_rd_vld;
  logic                r_rd_last;
  logic [RANK_W-1:0]   r_rd_data;
  logic                r_sk_vld;
  logic                r_sk_last;
  logic [RANK_W-1:0]   r_sk_data;
  logic                r_p1_vld;
  logic [P-1:0]        r_p1_addr;
  logic [RANK_W-1:0]   r_p1_rank;
  logic                r_p2_vld;
  logic [P-1:0]        r_p2_addr;
  logic [RANK_W-1:0]   r_p2_max;
  logic [RANK_W-1:0]   r_mem [NB];

  logic                w_accept;
  logic [P-1:0]        w_bucket;
  logic [FW-1:0]       w_field;
  logic [RANK_W-1:0]   w_rank;
  logic                w_fwd;
  logic [RANK_W-1:0]   w_stored;
  logic                w_upd_we;
  logic [RANK_W-1:0]   w_new;
  logic                w_pop;
  logic                w_out_free;
  logic [1:0]          w_dump_items;
  logic                w_issue;
  logic                w_rd_en;
  logic [P-1:0]        w_rd_addr;
  logic                w_wr_en;
  logic [P-1:0]        w_wr_addr;
  logic [RANK_W-1:0]   w_wr_data;
  logic                w_unused_tag;

  assign s_tready   = r_s_tready;
  assign m_tvalid   = r_m_tvalid;
  assign m_tlast    = r_m_tlast;
  assign m_tdata    = r_m_tdata;
  assign busy       = r_busy;
  assign item_count = r_item_count;

  // Lane tag carries no hash entropy.
  assign w_unused_tag = ^s_tdata[2:0];

  assign w_accept = r_s_tready && s_tvalid;
  assign w_bucket = s_tdata[63 -: P];
  assign w_field  = s_tdata[63-P:3];

  // Rank = leading-zero count of the field + 1; highest set bit wins.
  always_comb begin
    w_rank = RANK_W'(RANK_SAT);
    for (int i = 0; i < int'(FW); i++) begin
      if (w_field[i]) w_rank = RANK_W'(int'(FW) - i);
    end
  end

  // S2: the previous S2 result is newer than the RAM read when addresses match.
  assign w_fwd    = r_p2_vld && (r_p2_addr == r_p1_addr);
  assign w_stored = w_fwd ? r_p2_max : r_rd_data;
  assign w_upd_we = r_p1_vld && (r_p1_rank > w_stored);
  assign w_new    = w_upd_we ? r_p1_rank : w_stored;

  // Read only when output + skid can absorb everything in flight next cycle.
  assign w_pop        = r_m_tvalid && m_tready;
  assign w_out_free   = !r_m_tvalid || m_tready;
  assign w_dump_items = 2'(r_m_tvalid) + 2'(r_sk_vld) + 2'(r_rd_vld) - 2'(w_pop);
  assign w_issue      = (r_state == S_DUMP) && !r_rd_addr[P] && (w_dump_items <= 2'd1);

  assign w_rd_en   = w_accept || w_issue;
  assign w_rd_addr = (r_state == S_DUMP) ? r_rd_addr[P-1:0] : w_bucket;
  assign w_wr_en   = (r_state == S_CLEAR) || w_upd_we;
  assign w_wr_addr = (r_state == S_CLEAR) ? r_clr_addr : r_p1_addr;
  assign w_wr_data = (r_state == S_CLEAR) ? '0 : r_p1_rank;

  always_ff @(posedge aclk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
    if (w_rd_en) r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= S_CLEAR;
      r_s_tready   <= 1'b0;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_m_tdata    <= '0;
      r_busy       <= 1'b1;
      r_item_count <= '0;
      r_clr_addr   <= '0;
      r_rd_addr    <= '0;
      r_rd_vld     <= 1'b0;
      r_rd_last    <= 1'b0;
      r_sk_vld     <= 1'b0;
      r_sk_last    <= 1'b0;
      r_sk_data    <= '0;
      r_p1_vld     <= 1'b0;
      r_p1_addr    <= '0;
      r_p1_rank    <= '0;
      r_p2_vld     <= 1'b0;
      r_p2_addr    <= '0;
      r_p2_max     <= '0;
    end else begin
      r_p1_vld  <= w_accept;
      r_p1_addr <= w_bucket;
      r_p1_rank <= w_rank;
      r_p2_vld  <= r_p1_vld;
      r_p2_addr <= r_p1_addr;
      r_p2_max  <= w_new;
      r_rd_vld  <= w_issue;
      if (w_issue) begin
        r_rd_addr <= r_rd_addr + (P+1)'(1);
        r_rd_last <= (r_rd_addr[P-1:0] == '1);
      end
      if (w_accept) r_item_count <= r_item_count + CNT_W'(1);

      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + P'(1);
          if (r_clr_addr == '1) begin
            r_state      <= S_RUN;
            r_s_tready   <= 1'b1;
            r_busy       <= 1'b0;
            r_item_count <= '0;
          end
        end
        S_RUN: begin
          r_busy <= w_accept || dump_req;
          if (dump_req) begin
            r_state    <= S_DRAIN;
            r_s_tready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!r_p1_vld) begin
            r_state   <= S_DUMP;
            r_rd_addr <= '0;
          end
        end
        S_DUMP: begin
          // Output register is refilled from the skid first, then from the RAM read.
          if (w_out_free) begin
            if (r_sk_vld) begin
              r_m_tdata  <= OUT_W'(r_sk_data);
              r_m_tlast  <= r_sk_last;
              r_m_tvalid <= 1'b1;
              r_sk_vld   <= r_rd_vld;
              r_sk_data  <= r_rd_data;
              r_sk_last  <= r_rd_last;
            end else if (r_rd_vld) begin
              r_m_tdata  <= OUT_W'(r_rd_data);
              r_m_tlast  <= r_rd_last;
              r_m_tvalid <= 1'b1;
            end else begin
              r_m_tvalid <= 1'b0;
              r_m_tlast  <= 1'b0;
            end
          end else if (r_rd_vld) begin
            r_sk_vld  <= 1'b1;
            r_sk_data <= r_rd_data;
            r_sk_last <= r_rd_last;
          end
          if (w_pop && r_m_tlast) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule
